// File: rtl/pipeline_pkg.sv
// Shared constants and fetch FSM encoding for the RISC-V pipeline.
package pipeline_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, absolute load, or step by one word.
module fetch_pc_reg
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        inc_i,
    input  logic [31:0] load_pc_i,
    output logic [31:0] pc_o,
    output logic [31:0] pc_plus4_o
);

    logic [31:0] pc_q;

    // Load has priority over increment so a redirect always wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (load_i) begin
            pc_q <= load_pc_i;
        end else if (inc_i) begin
            pc_q <= pc_q + PC_STEP;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus4_o = pc_q + PC_STEP;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a single-outstanding imem request
// and feeds the IF/ID register, absorbing stalls and EX redirects.
module fetch_stage
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = pipeline_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = pipeline_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectPc,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemReady,
    input  logic [31:0] imemRdata,
    output logic [31:0] instructionOUT,
    output logic [31:0] pcOUT,
    output logic [31:0] pcPlus4OUT,
    output logic        fdWe,
    output logic        fdFlush
);

    fetch_state_e state_q, state_d;
    logic [31:0]  req_addr_q, req_addr_d;
    logic [31:0]  hold_instr_q, hold_instr_d;
    logic [31:0]  hold_pc_q, hold_pc_d;
    logic [31:0]  pc, pc_plus4, target, pc_load_val;
    logic         pc_load, pc_inc;

    assign target = word_align(redirectPc);

    fetch_pc_reg #(.RESET_PC(RESET_PC)) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_pc_i  (pc_load_val),
        .pc_o       (pc),
        .pc_plus4_o (pc_plus4)
    );

    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        hold_instr_d   = hold_instr_q;
        hold_pc_d      = hold_pc_q;
        pc_load        = 1'b0;
        pc_inc         = 1'b0;
        pc_load_val    = target;
        imemReq        = 1'b0;
        fdWe           = 1'b0;
        fdFlush        = 1'b0;
        instructionOUT = NOP_INSTR;
        pcOUT          = pc;
        case (state_q)
            FETCH: begin
                imemReq        = 1'b1;
                instructionOUT = imemRdata;
                if (redirect) begin
                    fdFlush = 1'b1;
                    pc_load = 1'b1;
                    // An in-flight request must complete at its old address first.
                    if (imemReady) req_addr_d = target;
                    else           state_d    = DROP;
                end else if (imemReady) begin
                    if (!stall) begin
                        fdWe       = 1'b1;
                        pc_inc     = 1'b1;
                        req_addr_d = pc_plus4;
                    end else begin
                        hold_instr_d = imemRdata;
                        hold_pc_d    = pc;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                instructionOUT = hold_instr_q;
                pcOUT          = hold_pc_q;
                if (redirect) begin
                    fdFlush    = 1'b1;
                    pc_load    = 1'b1;
                    req_addr_d = target;
                    state_d    = FETCH;
                end else if (!stall) begin
                    fdWe        = 1'b1;
                    pc_load     = 1'b1;
                    pc_load_val = hold_pc_q + PC_STEP;
                    req_addr_d  = hold_pc_q + PC_STEP;
                    state_d     = FETCH;
                end
            end
            DROP: begin
                imemReq = 1'b1;
                if (redirect) begin
                    fdFlush = 1'b1;
                    pc_load = 1'b1;
                end
                if (imemReady) begin
                    req_addr_d = redirect ? target : pc;
                    state_d    = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
        if (reset) begin
            imemReq        = 1'b0;
            fdWe           = 1'b0;
            fdFlush        = 1'b0;
            instructionOUT = NOP_INSTR;
            pcOUT          = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FETCH;
            req_addr_q   <= RESET_PC;
            hold_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Held PC is only read in HOLD, which is always entered by writing it.
    always_ff @(posedge clk) begin
        hold_pc_q <= hold_pc_d;
    end

    assign imemAddr   = req_addr_q;
    assign pcPlus4OUT = pcOUT + PC_STEP;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage with a variable-latency imem model.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, imemReady;
    logic [31:0] redirectPc, imemRdata;
    logic        imemReq, fdWe, fdFlush;
    logic [31:0] imemAddr, instructionOUT, pcOUT, pcPlus4OUT;

    fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect       (redirect),
        .redirectPc     (redirectPc),
        .imemReq        (imemReq),
        .imemAddr       (imemAddr),
        .imemReady      (imemReady),
        .imemRdata      (imemRdata),
        .instructionOUT (instructionOUT),
        .pcOUT          (pcOUT),
        .pcPlus4OUT     (pcPlus4OUT),
        .fdWe           (fdWe),
        .fdFlush        (fdFlush)
    );

    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;

    // Expected PC of the next instruction IF/ID should receive.
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Stimulus and memory model
    initial begin
        int          rst_cnt;
        int          lat;
        bit          pending;
        logic [31:0] paddr;
        rst_cnt = 0; lat = 0; pending = 1'b0; paddr = '0;
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = '0;
        imemReady = 1'b0; imemRdata = '0;
        exp_q = {RST_PC};
        repeat (2) @(posedge clk);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            if (rst_cnt > 0) rst_cnt--;
            else if ($urandom_range(0, 399) == 0) rst_cnt = $urandom_range(1, 2);
            reset      = (rst_cnt > 0);
            stall      = ($urandom_range(0, 3) == 0);
            redirect   = ($urandom_range(0, 11) == 0);
            redirectPc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : $urandom;
            #1;
            if (reset) begin
                pending   = 1'b0;
                imemReady = 1'($urandom_range(0, 1));
                imemRdata = $urandom;
            end else if (imemReq) begin
                if (!pending) begin
                    pending = 1'b1;
                    lat     = $urandom_range(0, 3);
                    paddr   = imemAddr;
                end else begin
                    check("imem_addr_stable", imemAddr, paddr);
                end
                imemRdata = mem_word(imemAddr);
                if (lat == 0) begin
                    imemReady = 1'b1;
                    pending   = 1'b0;
                end else begin
                    imemReady = 1'b0;
                    lat--;
                end
            end else begin
                imemReady = 1'b0;
                imemRdata = $urandom;
            end
            if (reset)         exp_q = {RST_PC};
            else if (redirect) exp_q = {redirectPc & ~32'd3};
        end
        @(posedge clk);
        #1;
        check("progress", 32'(delivered >= 200), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Monitor
    bit after_rst = 1'b0;
    bit in_hold   = 1'b0;
    bit in_drop   = 1'b0;

    always @(negedge clk) begin
        logic [31:0] e;
        if (reset) begin
            check("rst_imemReq", 32'(imemReq), 32'd0);
            check("rst_fdWe", 32'(fdWe), 32'd0);
            check("rst_fdFlush", 32'(fdFlush), 32'd0);
            check("rst_instr", instructionOUT, NOP);
            check("rst_pcOUT", pcOUT, RST_PC);
            after_rst = 1'b1;
            in_hold   = 1'b0;
            in_drop   = 1'b0;
        end else begin
            if (after_rst) begin
                check("first_req_valid", 32'(imemReq), 32'd1);
                check("first_req_addr", imemAddr, RST_PC);
                after_rst = 1'b0;
            end
            check("flush_on_redirect", 32'(fdFlush), 32'(redirect));
            if (in_hold) check("no_req_in_hold", 32'(imemReq), 32'd0);
            if (in_drop) check("no_write_while_dropping", 32'(fdWe), 32'd0);
            if (fdWe) begin
                check("write_not_stalled", 32'(stall), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty actual=%h expected=none", pcOUT);
                end else begin
                    e = exp_q.pop_front();
                    check("pcOUT", pcOUT, e);
                    check("instructionOUT", instructionOUT, mem_word(e));
                    check("pcPlus4OUT", pcPlus4OUT, e + 32'd4);
                    exp_q.push_back(e + 32'd4);
                    delivered++;
                end
            end
            if (in_hold)      in_hold = stall && !redirect;
            else if (in_drop) in_hold = 1'b0;
            else              in_hold = imemReq && imemReady && stall && !redirect;
            if (in_drop) in_drop = !imemReady;
            else         in_drop = imemReq && !imemReady && redirect;
        end
    end

endmodule
